// File: rtl/scope_uart_framer.sv
// Captures a 2**ADDR_W block of ADC samples on arm, then frames it out to the UART
// transmitter as SYNC, LEN, payload[, checksum]. Checksum byte built only with SCOPE_FRAMER_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for arm
// CAPTURE  | writing qualified samples into the buffer
// SYNC     | sending SYNC_BYTE
// LEN      | sending DEPTH-1
// DATA     | sending buffer contents in order
// CSUM     | sending the checksum (checksum build only)
// DRAIN    | waiting for the last byte to leave the transmitter
module scope_uart_framer #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_arm,
  input  logic       i_smp_valid,
  input  logic [7:0] i_smp_data,
  input  logic       i_txd_busy,
  output logic       o_txd_start,
  output logic [7:0] o_txd_data,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [7:0]        LEN_BYTE = 8'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CAPTURE, ST_SYNC, ST_LEN, ST_DATA, ST_CSUM, ST_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [7:0]        r_buf [DEPTH];
  logic              r_txd_start;
  logic [7:0]        r_txd_data;
  logic              w_can_send;
  logic              w_send;
  logic              w_wr;
  logic [7:0]        w_send_byte;
  logic [7:0]        w_rd_byte;
`ifdef SCOPE_FRAMER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  // The transmitter raises busy a cycle late, so the cycle after a start is always skipped.
  assign w_can_send  = !i_txd_busy && !r_txd_start;
  assign w_rd_byte   = r_buf[r_rptr];
  assign o_txd_start = r_txd_start;
  assign o_txd_data  = r_txd_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_arm) w_next = ST_CAPTURE;
      ST_CAPTURE: if (i_smp_valid && (r_wptr == LAST_PTR)) w_next = ST_SYNC;
      ST_SYNC:    if (w_can_send) w_next = ST_LEN;
      ST_LEN:     if (w_can_send) w_next = ST_DATA;
      ST_DATA: begin
        if (w_can_send && (r_rptr == LAST_PTR)) begin
`ifdef SCOPE_FRAMER_CHECKSUM_EN
          w_next = ST_CSUM;
`else
          w_next = ST_DRAIN;
`endif
        end
      end
`ifdef SCOPE_FRAMER_CHECKSUM_EN
      ST_CSUM:    if (w_can_send) w_next = ST_DRAIN;
`endif
      ST_DRAIN:   if (w_can_send) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != ST_IDLE);
    o_frame_done = (r_state == ST_DRAIN) && w_can_send;
    w_wr         = (r_state == ST_CAPTURE) && i_smp_valid;
    w_send       = 1'b0;
    w_send_byte  = 8'h00;
    case (r_state)
      ST_SYNC: begin
        w_send      = w_can_send;
        w_send_byte = SYNC_BYTE;
      end
      ST_LEN: begin
        w_send      = w_can_send;
        w_send_byte = LEN_BYTE;
      end
      ST_DATA: begin
        w_send      = w_can_send;
        w_send_byte = w_rd_byte;
      end
`ifdef SCOPE_FRAMER_CHECKSUM_EN
      ST_CSUM: begin
        w_send      = w_can_send;
        w_send_byte = r_csum;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txd_start <= 1'b0;
      r_txd_data  <= 8'h00;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_txd_start <= w_send;
      if (w_send) r_txd_data <= w_send_byte;

      if ((r_state == ST_IDLE) && i_arm) r_wptr <= '0;
      else if (w_wr)                     r_wptr <= r_wptr + 1'b1;

      if ((r_state == ST_IDLE) && i_arm)        r_rptr <= '0;
      else if ((r_state == ST_DATA) && w_send)  r_rptr <= r_rptr + 1'b1;
    end
  end

`ifdef SCOPE_FRAMER_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             r_csum <= 8'h00;
    else if ((r_state == ST_LEN) && w_send)   r_csum <= LEN_BYTE;
    else if ((r_state == ST_DATA) && w_send)  r_csum <= r_csum + w_rd_byte;
  end
`endif

  // Sample buffer is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_buf[r_wptr] <= i_smp_data;
  end

endmodule

// File: tb/tb_scope_uart_framer.sv
// Bench for scope_uart_framer (ADDR_W=2): vector table, hand-written corner sequences and
// random frames checked against a queue-based frame model with an 11-tick-style transmitter.
module tb_scope_uart_framer;
  localparam int         AW    = 2;
  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;
`ifdef SCOPE_FRAMER_CHECKSUM_EN
  localparam int FLEN = DEPTH + 3;
`else
  localparam int FLEN = DEPTH + 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       smp_valid = 1'b0;
  logic [7:0] smp_data = 8'h00;
  logic       txd_busy;
  logic       txd_start;
  logic [7:0] txd_data;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  scope_uart_framer #(.ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_smp_valid(smp_valid),
    .i_smp_data(smp_data), .i_txd_busy(txd_busy), .o_txd_start(txd_start),
    .o_txd_data(txd_data), .o_busy(busy), .o_frame_done(frame_done)
  );

  // Transmitter model: busy rises the cycle after a start and lasts hold cycles.
  int         tx_cnt = 0;
  int         hold_def = 11;
  int         stall_idx = -1;
  int         stall_len = 0;
  int         frame_base = 0;
  logic [7:0] got_q[$];
  int         viol_cnt = 0;
  int         fd_cnt = 0;
  logic       prev_start = 1'b0;

  assign txd_busy = (tx_cnt != 0);

  always @(posedge clk) begin
    if (txd_start)
      tx_cnt <= ((got_q.size() - 1 - frame_base) == stall_idx) ? stall_len : hold_def;
    else if (tx_cnt > 0)
      tx_cnt <= tx_cnt - 1;
  end

  always @(negedge clk) begin
    if (txd_start) begin
      got_q.push_back(txd_data);
      if (txd_busy || prev_start) viol_cnt++;
    end
    prev_start = txd_start;
    if (frame_done) fd_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [7:0] exp_q[$];

  function automatic logic [7:0] sum_csum(input logic [31:0] pay);
    int s;
    s = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) s += pay[8*i +: 8];
    return 8'(s % 256);
  endfunction

  task automatic build_exp(input logic [31:0] pay, input logic [7:0] csum);
    exp_q.delete();
    exp_q.push_back(SYNC);
    exp_q.push_back(8'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(pay[8*i +: 8]);
`ifdef SCOPE_FRAMER_CHECKSUM_EN
    exp_q.push_back(csum);
`else
    if (csum == 8'h00) exp_q.delete(FLEN);  // csum unused in this build
`endif
  endtask

  // Arms, feeds DEPTH samples (with optional gaps), waits for frame_done and checks the frame.
  task automatic do_frame(input logic [31:0] pay, input int gap_mode, input int arm_at,
                          input string tag);
    int  base_fd, base_viol, waited, ngap;
    bit  done, rearmed;
    frame_base = got_q.size();
    base_fd    = fd_cnt;
    base_viol  = viol_cnt;
    arm = 1'b1; smp_valid = 1'b1; smp_data = 8'hEE;
    tick();
    arm = 1'b0;
    check({tag, " busy after arm"}, busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      ngap = (i == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < ngap; g++) begin
        smp_valid = 1'b0; smp_data = 8'($urandom);
        tick();
      end
      smp_valid = 1'b1; smp_data = pay[8*i +: 8];
      tick();
    end
    check({tag, " no start during capture"}, got_q.size() - frame_base, 0);
    waited = 0; done = 1'b0; rearmed = 1'b0;
    while (!done && waited < 3000) begin
      smp_valid = 1'($urandom_range(0, 1));
      smp_data  = 8'($urandom);
      if (arm_at >= 0 && !rearmed && (got_q.size() - frame_base) == arm_at) begin
        arm = 1'b1; rearmed = 1'b1;
      end else begin
        arm = 1'b0;
      end
      tick();
      waited++;
      if (fd_cnt != base_fd) done = 1'b1;
    end
    arm = 1'b0; smp_valid = 1'b0;
    check({tag, " frame_done seen"}, done, 1);
    check({tag, " bytes at frame_done"}, got_q.size() - frame_base, FLEN);
    check({tag, " busy at frame_done"}, busy, 1);
    tick();
    check({tag, " busy after frame_done"}, busy, 0);
    repeat (30) tick();
    check({tag, " frame_done count"}, fd_cnt - base_fd, 1);
    check({tag, " byte count"}, got_q.size() - frame_base, FLEN);
    check({tag, " handshake violations"}, viol_cnt - base_viol, 0);
    for (int k = 0; k < FLEN; k++)
      if (frame_base + k < got_q.size())
        check($sformatf("%s byte%0d", tag, k), got_q[frame_base + k], exp_q[k]);
  endtask

  typedef struct {
    logic [31:0] pay;
    int          gap;
    int          hold;
    int          sidx;
    int          slen;
    int          arm_at;
    logic [31:0] exp_pay;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t vt[5];

  initial begin
    int waited;
    logic [31:0] rp;
    vt[0] = '{32'h04030201, 0, 11, -1,  0, -1, 32'h04030201, 8'h0D};
    vt[1] = '{32'h40302010, 1, 11, -1,  0, -1, 32'h40302010, 8'hA3};
    vt[2] = '{32'hFF00C35A, 0,  5,  3, 40, -1, 32'hFF00C35A, 8'h1F};
    vt[3] = '{32'h44332211, 0,  7, -1,  0,  3, 32'h44332211, 8'hAD};
    vt[4] = '{32'h7F8001FE, 0,  0, -1,  0, -1, 32'h7F8001FE, 8'h01};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset txd_start", txd_start, 0);
      check("reset txd_data", txd_data, 0);
      check("reset busy", busy, 0);
      check("reset frame_done", frame_done, 0);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle after reset busy", busy, 0);
    check("idle after reset starts", got_q.size(), 0);

    for (int v = 0; v < 5; v++) begin
      hold_def = vt[v].hold; stall_idx = vt[v].sidx; stall_len = vt[v].slen;
      build_exp(vt[v].exp_pay, vt[v].exp_csum);
      do_frame(vt[v].pay, vt[v].gap, vt[v].arm_at, $sformatf("vec%0d", v));
    end

    // Reset while a DATA byte is being handed off, then a fresh frame.
    hold_def = 6; stall_idx = -1;
    frame_base = got_q.size();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      smp_valid = 1'b1; smp_data = 8'(8'h31 + i); tick();
    end
    smp_valid = 1'b0;
    waited = 0;
    while ((got_q.size() - frame_base) < 4 && waited < 500) begin
      tick(); waited++;
    end
    check("midreset reached DATA", got_q.size() - frame_base, 4);
    rst_n = 1'b0;
    #1;
    check("midreset txd_start", txd_start, 0);
    check("midreset txd_data", txd_data, 0);
    check("midreset busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    build_exp(32'h04030201, 8'h0D);
    do_frame(32'h04030201, 0, -1, "post_reset");

    for (int r = 0; r < 12; r++) begin
      rp        = $urandom;
      hold_def  = $urandom_range(0, 13);
      stall_idx = $urandom_range(0, FLEN - 1);
      stall_len = $urandom_range(0, 30);
      build_exp(rp, sum_csum(rp));
      do_frame(rp, 2, (r % 3 == 0) ? int'($urandom_range(1, FLEN - 1)) : -1,
               $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
